video_timing_gen: RTL and testbench



---
 rtl/video_timing_pkg.sv | 35 +++
 rtl/timing_axis_counter.sv | 55 +++++
 rtl/video_timing_gen.sv | 142 ++++++++++++++
 tb/tb_video_timing_gen.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/video_timing_pkg.sv
// Shared raster timing constants and helpers for the video path.
// Game logic imports the same sync-region checks the timing generator uses.
package video_timing_pkg;

    localparam int DEF_H_DISPLAY = 640;
    localparam int DEF_H_FRONT   = 16;
    localparam int DEF_H_SYNC    = 96;
    localparam int DEF_H_BACK    = 48;
    localparam int DEF_V_DISPLAY = 480;
    localparam int DEF_V_BOTTOM  = 10;
    localparam int DEF_V_SYNC    = 2;
    localparam int DEF_V_TOP     = 33;
    localparam int DEF_CNT_W     = 10;

    function automatic int h_total(input int display, input int front,
                                   input int sync, input int back);
        return display + front + sync + back;
    endfunction

    function automatic int v_total(input int display, input int bottom,
                                   input int sync, input int top);
        return display + bottom + sync + top;
    endfunction

    // Sync occupies the slot directly after the front porch.
    function automatic logic in_sync_region(input int pos, input int display,
                                            input int front, input int sync);
        return (pos >= display + front) && (pos < display + front + sync);
    endfunction

    function automatic logic fits_width(input int value, input int w);
        return longint'(value) < (longint'(1) << w);
    endfunction

endpackage

// File: rtl/timing_axis_counter.sv
// One raster axis: position counter with registered sync and active flags
// derived from the next position, so they line up with pos every cycle.
module timing_axis_counter
    import video_timing_pkg::*;
#(
    parameter int   DISPLAY = DEF_H_DISPLAY,
    parameter int   FRONT   = DEF_H_FRONT,
    parameter int   SYNC    = DEF_H_SYNC,
    parameter int   BACK    = DEF_H_BACK,
    parameter logic POL     = 1'b1,
    parameter int   W       = DEF_CNT_W
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         step,
    output logic [W-1:0] pos,
    output logic         wrap,
    output logic         sync,
    output logic         active
);

    localparam int TOTAL = h_total(DISPLAY, FRONT, SYNC, BACK);

    logic [W-1:0] pos_q, pos_d;
    logic         sync_q, sync_d;
    logic         active_q, active_d;

    assign wrap = (pos_q == W'(TOTAL - 1));

    always_comb begin
        pos_d = pos_q;
        if (step) begin
            pos_d = wrap ? '0 : pos_q + W'(1);
        end
        sync_d   = in_sync_region(int'(pos_d), DISPLAY, FRONT, SYNC) ? POL : ~POL;
        active_d = (int'(pos_d) < DISPLAY);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pos_q    <= '0;
            sync_q   <= ~POL;
            active_q <= 1'b1;
        end else begin
            pos_q    <= pos_d;
            sync_q   <= sync_d;
            active_q <= active_d;
        end
    end

    assign pos    = pos_q;
    assign sync   = sync_q;
    assign active = active_q;

endmodule

// File: rtl/video_timing_gen.sv
// Parametrised raster timing generator with pixel prescaler, freeze enable,
// line/frame strobes and a frame counter; all outputs describe the same pixel.
module video_timing_gen
    import video_timing_pkg::*;
#(
    parameter int H_DISPLAY  = DEF_H_DISPLAY,
    parameter int H_FRONT    = DEF_H_FRONT,
    parameter int H_SYNC     = DEF_H_SYNC,
    parameter int H_BACK     = DEF_H_BACK,
    parameter int V_DISPLAY  = DEF_V_DISPLAY,
    parameter int V_BOTTOM   = DEF_V_BOTTOM,
    parameter int V_SYNC     = DEF_V_SYNC,
    parameter int V_TOP      = DEF_V_TOP,
    parameter int H_SYNC_POL = 1,
    parameter int V_SYNC_POL = 1,
    parameter int CNT_W      = DEF_CNT_W,
    parameter int PIX_DIV    = 1,
    parameter int FRAME_W    = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               en,
    output logic               hsync,
    output logic               vsync,
    output logic               display_on,
    output logic [CNT_W-1:0]   hpos,
    output logic [CNT_W-1:0]   vpos,
    output logic               pix_ce,
    output logic               line_start,
    output logic               frame_start,
    output logic [FRAME_W-1:0] frame_cnt
);

    localparam int H_TOTAL = h_total(H_DISPLAY, H_FRONT, H_SYNC, H_BACK);
    localparam int V_TOTAL = v_total(V_DISPLAY, V_BOTTOM, V_SYNC, V_TOP);
    localparam int DIV_W   = (PIX_DIV > 1) ? $clog2(PIX_DIV) : 1;

    if (PIX_DIV < 1) begin : g_bad_div
        $error("video_timing_gen: PIX_DIV must be at least 1");
    end
    if (H_FRONT < 1 || H_SYNC < 1 || H_BACK < 1 ||
        V_BOTTOM < 1 || V_SYNC < 1 || V_TOP < 1) begin : g_bad_porch
        $error("video_timing_gen: porch and sync widths must be at least 1");
    end
    if (!fits_width(H_TOTAL - 1, CNT_W) || !fits_width(V_TOTAL - 1, CNT_W)) begin : g_bad_width
        $error("video_timing_gen: CNT_W too narrow for the line/frame totals");
    end

    logic [DIV_W-1:0]   div_q, div_d;
    logic [FRAME_W-1:0] frame_cnt_q, frame_cnt_d;
    logic               pce_q, pce_d;
    logic               line_q, line_d;
    logic               frame_q, frame_d;

    logic               div_wrap, h_step, v_step;
    logic               h_wrap, v_wrap, h_sync, v_sync, h_active, v_active;
    logic [CNT_W-1:0]   h_pos, v_pos;
    logic               h_next_zero, v_next_zero;

    assign div_wrap = (div_q == DIV_W'(PIX_DIV - 1));
    assign h_step   = en & div_wrap;
    assign v_step   = h_step & h_wrap;

    timing_axis_counter #(
        .DISPLAY (H_DISPLAY),
        .FRONT   (H_FRONT),
        .SYNC    (H_SYNC),
        .BACK    (H_BACK),
        .POL     (H_SYNC_POL != 0),
        .W       (CNT_W)
    ) u_h_axis (
        .clk    (clk),
        .reset  (reset),
        .step   (h_step),
        .pos    (h_pos),
        .wrap   (h_wrap),
        .sync   (h_sync),
        .active (h_active)
    );

    timing_axis_counter #(
        .DISPLAY (V_DISPLAY),
        .FRONT   (V_BOTTOM),
        .SYNC    (V_SYNC),
        .BACK    (V_TOP),
        .POL     (V_SYNC_POL != 0),
        .W       (CNT_W)
    ) u_v_axis (
        .clk    (clk),
        .reset  (reset),
        .step   (v_step),
        .pos    (v_pos),
        .wrap   (v_wrap),
        .sync   (v_sync),
        .active (v_active)
    );

    // Strobe flags are precomputed from the next div/position so they sit
    // in the same cycle as the pixel they mark.
    always_comb begin
        div_d = div_q;
        if (en) begin
            div_d = div_wrap ? '0 : div_q + DIV_W'(1);
        end
        frame_cnt_d = frame_cnt_q;
        if (v_step && v_wrap) begin
            frame_cnt_d = frame_cnt_q + FRAME_W'(1);
        end
        h_next_zero = h_step ? h_wrap : (h_pos == '0);
        v_next_zero = v_step ? v_wrap : (v_pos == '0);
        pce_d   = (div_d == '0);
        line_d  = pce_d & h_next_zero;
        frame_d = line_d & v_next_zero;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            div_q       <= '0;
            frame_cnt_q <= '0;
            pce_q       <= 1'b1;
            line_q      <= 1'b1;
            frame_q     <= 1'b1;
        end else begin
            div_q       <= div_d;
            frame_cnt_q <= frame_cnt_d;
            pce_q       <= pce_d;
            line_q      <= line_d;
            frame_q     <= frame_d;
        end
    end

    assign hsync       = h_sync;
    assign vsync       = v_sync;
    assign display_on  = h_active & v_active;
    assign hpos        = h_pos;
    assign vpos        = v_pos;
    assign frame_cnt   = frame_cnt_q;
    assign pix_ce      = pce_q & en & ~reset;
    assign line_start  = line_q & en & ~reset;
    assign frame_start = frame_q & en & ~reset;

endmodule

// File: tb/tb_video_timing_gen.sv
// Bench for video_timing_gen: three configurations checked against a
// cycle model through a scoreboard queue, plus a table of fixed vectors.
module tb_video_timing_gen;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst = 1'b1;
    logic en  = 1'b0;
    int   sel = 0;
    logic en0, en1, en2;
    assign en0 = en && (sel == 0);
    assign en1 = en && (sel == 1);
    assign en2 = en && (sel == 2);

    logic       a_hs, a_vs, a_disp, a_pce, a_ls, a_fs;
    logic [9:0] a_h, a_v;
    logic [7:0] a_fc;
    logic       b_hs, b_vs, b_disp, b_pce, b_ls, b_fs;
    logic [9:0] b_h, b_v;
    logic [7:0] b_fc;
    logic       s_hs, s_vs, s_disp, s_pce, s_ls, s_fs;
    logic [3:0] s_h, s_v;
    logic [1:0] s_fc;

    video_timing_gen u_def (
        .clk(clk), .reset(rst), .en(en0), .hsync(a_hs), .vsync(a_vs),
        .display_on(a_disp), .hpos(a_h), .vpos(a_v), .pix_ce(a_pce),
        .line_start(a_ls), .frame_start(a_fs), .frame_cnt(a_fc));

    video_timing_gen #(.PIX_DIV(3)) u_div3 (
        .clk(clk), .reset(rst), .en(en1), .hsync(b_hs), .vsync(b_vs),
        .display_on(b_disp), .hpos(b_h), .vpos(b_v), .pix_ce(b_pce),
        .line_start(b_ls), .frame_start(b_fs), .frame_cnt(b_fc));

    video_timing_gen #(
        .H_DISPLAY(8), .H_FRONT(1), .H_SYNC(2), .H_BACK(1),
        .V_DISPLAY(4), .V_BOTTOM(1), .V_SYNC(1), .V_TOP(1),
        .H_SYNC_POL(0), .V_SYNC_POL(0), .CNT_W(4), .FRAME_W(2)
    ) u_small (
        .clk(clk), .reset(rst), .en(en2), .hsync(s_hs), .vsync(s_vs),
        .display_on(s_disp), .hpos(s_h), .vpos(s_v), .pix_ce(s_pce),
        .line_start(s_ls), .frame_start(s_fs), .frame_cnt(s_fc));

    typedef struct packed {
        logic       hs, vs, disp, pce, ls, fs;
        logic [9:0] h, v;
        logic [7:0] fc;
    } obs_t;

    obs_t obs_act;
    always_comb begin
        obs_act = '0;
        case (sel)
            0: obs_act = {a_hs, a_vs, a_disp, a_pce, a_ls, a_fs, a_h, a_v, a_fc};
            1: obs_act = {b_hs, b_vs, b_disp, b_pce, b_ls, b_fs, b_h, b_v, b_fc};
            default: obs_act = {s_hs, s_vs, s_disp, s_pce, s_ls, s_fs,
                                6'd0, s_h, 6'd0, s_v, 6'd0, s_fc};
        endcase
    end

    typedef struct {
        int hd, hf, hsw, hb, vd, vb, vsw, vt;
        bit hpol, vpol;
        int pdiv, fw;
    } cfg_t;

    cfg_t cfg;
    int   mdiv, mh, mv, mfc;
    obs_t sbq[$];

    int checks = 0;
    int errors = 0;
    int cyc;
    int cnt_hs, cnt_disp, cnt_pce, cnt_ls, cnt_fs;
    int hs_first, ls_prev, ls_last, ls_run, ls_max;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %0h, want %0h", name, cyc, act, exp);
        end
    endtask

    function automatic obs_t model_obs(input logic en_now, input logic rst_now);
        obs_t o;
        o.h    = 10'(mh);
        o.v    = 10'(mv);
        o.fc   = 8'(mfc);
        o.hs   = (mh >= cfg.hd + cfg.hf && mh < cfg.hd + cfg.hf + cfg.hsw) ? cfg.hpol : !cfg.hpol;
        o.vs   = (mv >= cfg.vd + cfg.vb && mv < cfg.vd + cfg.vb + cfg.vsw) ? cfg.vpol : !cfg.vpol;
        o.disp = (mh < cfg.hd) && (mv < cfg.vd);
        o.pce  = en_now && !rst_now && (mdiv == 0);
        o.ls   = o.pce && (mh == 0);
        o.fs   = o.ls && (mv == 0);
        return o;
    endfunction

    task automatic model_step(input logic en_v);
        int ht, vtot;
        ht   = cfg.hd + cfg.hf + cfg.hsw + cfg.hb;
        vtot = cfg.vd + cfg.vb + cfg.vsw + cfg.vt;
        if (en_v) begin
            if (mdiv == cfg.pdiv - 1) begin
                mdiv = 0;
                if (mh == ht - 1) begin
                    mh = 0;
                    if (mv == vtot - 1) begin
                        mv  = 0;
                        mfc = (mfc + 1) % (1 << cfg.fw);
                    end else begin
                        mv++;
                    end
                end else begin
                    mh++;
                end
            end else begin
                mdiv++;
            end
        end
    endtask

    task automatic clear_stats();
        cnt_hs = 0; cnt_disp = 0; cnt_pce = 0; cnt_ls = 0; cnt_fs = 0;
        hs_first = -1; ls_prev = 0; ls_last = 0; ls_run = 0; ls_max = 0;
    endtask

    task automatic run(input int n, input logic en_v);
        obs_t e;
        for (int i = 0; i < n; i++) begin
            en = en_v;
            model_step(en_v);
            sbq.push_back(model_obs(en_v, 1'b0));
            @(posedge clk);
            @(negedge clk);
            e = sbq.pop_front();
            cyc++;
            check("scoreboard", 64'(obs_act), 64'(e));
            if (obs_act.hs == cfg.hpol) begin
                cnt_hs++;
                if (hs_first < 0) hs_first = cyc;
            end
            if (obs_act.disp) cnt_disp++;
            if (obs_act.pce)  cnt_pce++;
            if (obs_act.fs)   cnt_fs++;
            if (obs_act.ls) begin
                cnt_ls++;
                ls_prev = ls_last;
                ls_last = cyc;
                ls_run++;
                if (ls_run > ls_max) ls_max = ls_run;
            end else begin
                ls_run = 0;
            end
        end
    endtask

    task automatic model_reset();
        mdiv = 0; mh = 0; mv = 0; mfc = 0;
        sbq.delete();
    endtask

    task automatic apply_reset(input int sel_v);
        @(negedge clk);
        sel = sel_v;
        case (sel_v)
            0: cfg = '{640, 16, 96, 48, 480, 10, 2, 33, 1'b1, 1'b1, 1, 8};
            1: cfg = '{640, 16, 96, 48, 480, 10, 2, 33, 1'b1, 1'b1, 3, 8};
            default: cfg = '{8, 1, 2, 1, 4, 1, 1, 1, 1'b0, 1'b0, 1, 2};
        endcase
        en  = 1'b0;
        rst = 1'b1;
        model_reset();
        #2;
        check("reset_held", 64'(obs_act), 64'(model_obs(1'b0, 1'b1)));
        rst = 1'b0;
        #1;
        check("reset_released_en0", 64'(obs_act), 64'(model_obs(1'b0, 1'b0)));
        en = 1'b1;
        #1;
        check("reset_released_en1", 64'(obs_act), 64'(model_obs(1'b1, 1'b0)));
        cyc = 0;
        clear_stats();
    endtask

    typedef struct {
        int         k;
        logic [9:0] h, v;
        logic       hs, vs, disp, ls, fs;
        logic [7:0] fc;
    } vec_t;

    vec_t tbl[15];

    initial begin
        tbl[0]  = '{0,   10'd0,  10'd0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 8'd0};
        tbl[1]  = '{1,   10'd1,  10'd0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'd0};
        tbl[2]  = '{8,   10'd8,  10'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0};
        tbl[3]  = '{9,   10'd9,  10'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0};
        tbl[4]  = '{10,  10'd10, 10'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0};
        tbl[5]  = '{11,  10'd11, 10'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0};
        tbl[6]  = '{12,  10'd0,  10'd1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 8'd0};
        tbl[7]  = '{55,  10'd7,  10'd4, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0};
        tbl[8]  = '{60,  10'd0,  10'd5, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'd0};
        tbl[9]  = '{70,  10'd10, 10'd5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0};
        tbl[10] = '{72,  10'd0,  10'd6, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 8'd0};
        tbl[11] = '{84,  10'd0,  10'd0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 8'd1};
        tbl[12] = '{168, 10'd0,  10'd0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 8'd2};
        tbl[13] = '{335, 10'd11, 10'd6, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'd3};
        tbl[14] = '{336, 10'd0,  10'd0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 8'd0};
        cyc = 0;
        clear_stats();

        // Small active-low timing: fixed vectors over several frames.
        apply_reset(2);
        for (int i = 0; i < 15; i++) begin
            run(tbl[i].k - cyc, 1'b1);
            check($sformatf("vector_k%0d", tbl[i].k),
                  64'({obs_act.h, obs_act.v, obs_act.hs, obs_act.vs, obs_act.disp,
                       obs_act.ls, obs_act.fs, obs_act.fc}),
                  64'({tbl[i].h, tbl[i].v, tbl[i].hs, tbl[i].vs, tbl[i].disp,
                       tbl[i].ls, tbl[i].fs, tbl[i].fc}));
            if (tbl[i].k == 84) clear_stats();
            if (tbl[i].k == 168) begin
                check("small_disp_per_frame", 64'(cnt_disp), 64'd32);
                check("small_fs_per_frame", 64'(cnt_fs), 64'd1);
                check("small_ls_per_frame", 64'(cnt_ls), 64'd7);
            end
        end

        // Asynchronous reset between edges in the middle of a frame.
        run(41, 1'b1);
        check("small_pre_reset_pos", 64'({obs_act.h, obs_act.v}), 64'({10'd5, 10'd3}));
        #2;
        rst = 1'b1;
        model_reset();
        #1;
        check("async_reset_outputs", 64'(obs_act), 64'(model_obs(1'b1, 1'b1)));
        rst = 1'b0;
        #1;
        check("async_reset_release", 64'(obs_act), 64'(model_obs(1'b1, 1'b0)));
        run(89, 1'b1);

        // Defaults: one full line, then a freeze at hpos 300.
        apply_reset(0);
        run(800, 1'b1);
        check("def_hsync_clks", 64'(cnt_hs), 64'd96);
        check("def_hsync_first", 64'(hs_first), 64'd656);
        check("def_disp_clks", 64'(cnt_disp), 64'd640);
        check("def_ls_per_line", 64'(cnt_ls), 64'd1);
        run(300, 1'b1);
        check("def_hpos_300", 64'(obs_act.h), 64'd300);
        clear_stats();
        run(50, 1'b0);
        check("freeze_strobes", 64'(cnt_pce + cnt_ls + cnt_fs), 64'd0);
        check("freeze_hpos", 64'(obs_act.h), 64'd300);
        run(1, 1'b1);
        check("resume_hpos", 64'(obs_act.h), 64'd301);

        // Prescaler of 3.
        apply_reset(1);
        run(2400, 1'b1);
        check("div3_pce_count", 64'(cnt_pce), 64'd800);
        check("div3_ls_count", 64'(cnt_ls), 64'd1);
        run(2400, 1'b1);
        check("div3_line_period", 64'(ls_last - ls_prev), 64'd2400);
        check("div3_ls_width", 64'(ls_max), 64'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
